irq_trap_ctrl: RTL and testbench

Machine-mode interrupt controller and trap sequencer. It sits between the interrupt sources (external, software, timer) and the core's CSR file. It arbitrates pending interrupts by fixed priority and handshakes a pipeline drain before committing a trap. It then drives the trap-entry strobe, cause, EPC and target PC into the CSR file and tracks nesting until the matching MRET.

---
 rtl/irq_pkg.sv | 41 ++++
 rtl/irq_trap_ctrl_if.sv | 30 +++
 rtl/irq_trap_ctrl_sync.sv | 24 ++
 rtl/irq_trap_ctrl.sv | 147 ++++++++++++++
 tb/tb_irq_trap_ctrl.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/irq_pkg.sv
// Shared types and constants for the machine-mode interrupt controller / trap sequencer.
package irq_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned CAUSE_W = 4;

  typedef logic [CAUSE_W-1:0] cause_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_ENTER   = 2'd2,
    ST_HANDLER = 2'd3
  } irq_state_e;

  localparam cause_t CAUSE_MSI = 4'd3;
  localparam cause_t CAUSE_MTI = 4'd7;
  localparam cause_t CAUSE_MEI = 4'd11;

  localparam int unsigned MSIP_BIT = 3;
  localparam int unsigned MTIP_BIT = 7;
  localparam int unsigned MEIP_BIT = 11;

  localparam logic [XLEN-1:0] IRQ_EN_MASK   = 32'h0000_0888;
  localparam logic [1:0]      MTVEC_MODE_VEC = 2'b01;

  // Registered payload presented to the CSR file with the trap-entry strobe.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] epc;
  } trap_pkt_t;

  // Fixed priority: MEI > MSI > MTI; caller guarantees at least one bit pending.
  function automatic cause_t irq_arbitrate(input logic meip, input logic msip);
    if (meip)      return CAUSE_MEI;
    else if (msip) return CAUSE_MSI;
    else           return CAUSE_MTI;
  endfunction

endpackage

// File: rtl/irq_trap_ctrl_if.sv
// CSR-file / pipeline side bundle of the interrupt controller; master = core, slave = controller.
interface irq_trap_ctrl_if #(
  parameter int unsigned NEST_W = 2
);

  logic              mstatus_mie;
  logic [31:0]       mie;
  logic [31:0]       mtvec;
  logic              pipe_drained;
  logic [31:0]       retire_pc;
  logic              mret_exec;
  logic              pipe_flush_req;
  logic              trap_taken;
  logic [31:0]       trap_pc;
  logic [31:0]       trap_cause;
  logic [31:0]       trap_epc;
  logic [31:0]       mip;
  logic [NEST_W-1:0] nest_depth;

  modport master (
    output mstatus_mie, mie, mtvec, pipe_drained, retire_pc, mret_exec,
    input  pipe_flush_req, trap_taken, trap_pc, trap_cause, trap_epc, mip, nest_depth
  );

  modport slave (
    input  mstatus_mie, mie, mtvec, pipe_drained, retire_pc, mret_exec,
    output pipe_flush_req, trap_taken, trap_pc, trap_cause, trap_epc, mip, nest_depth
  );

endinterface

// File: rtl/irq_trap_ctrl_sync.sv
// Two-flop synchronizer for a level signal crossing into the clk domain.
module irq_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/irq_trap_ctrl.sv
// Machine-mode interrupt arbiter and trap sequencer (IDLE -> FLUSH -> ENTER -> HANDLER).
// Define IRQ_VECTORED_EN to honour vectored mtvec mode; otherwise trap_pc is always the mtvec base.
module irq_trap_ctrl
  import irq_pkg::*;
#(
  parameter int unsigned MAX_NEST = 2,
  parameter int unsigned NEST_W   = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            irq_ext,
  input  logic            irq_sw,
  input  logic            irq_timer,
  irq_trap_ctrl_if.slave  bus
);

  irq_state_e        state_q, state_d;
  cause_t            cause_q, cause_d;
  logic [NEST_W-1:0] nest_q, nest_d;
  logic              msip_q, mtip_q;
  logic              meip_sync;
  logic              flush_q, taken_q;
  trap_pkt_t         trap_q, trap_d;

  logic [XLEN-1:0]   mip_c;
  logic [XLEN-1:0]   pend_c;
  logic              take_c;
  cause_t            win_cause_c;
  logic [XLEN-1:0]   target_c;

  irq_sync u_ext_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (irq_ext),
    .q_o     (meip_sync)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      msip_q <= 1'b0;
      mtip_q <= 1'b0;
    end else begin
      msip_q <= irq_sw;
      mtip_q <= irq_timer;
    end
  end

  always_comb begin
    mip_c           = '0;
    mip_c[MSIP_BIT] = msip_q;
    mip_c[MTIP_BIT] = mtip_q;
    mip_c[MEIP_BIT] = meip_sync;
  end

  assign pend_c      = mip_c & bus.mie & IRQ_EN_MASK;
  assign take_c      = bus.mstatus_mie & (|pend_c) & ~bus.mret_exec
                     & (nest_q < NEST_W'(MAX_NEST));
  assign win_cause_c = irq_arbitrate(pend_c[MEIP_BIT], pend_c[MSIP_BIT]);

  // Redirect target uses the cause frozen at FLUSH entry.
`ifdef IRQ_VECTORED_EN
  always_comb begin
    target_c = {bus.mtvec[31:2], 2'b00};
    if (bus.mtvec[1:0] == MTVEC_MODE_VEC) begin
      target_c = {bus.mtvec[31:2], 2'b00} + {26'b0, cause_q, 2'b00};
    end
  end
`else
  logic unused_mtvec_mode;
  assign unused_mtvec_mode = ^bus.mtvec[1:0];
  assign target_c          = {bus.mtvec[31:2], 2'b00};
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cause_q <= '0;
      nest_q  <= '0;
      flush_q <= 1'b0;
      taken_q <= 1'b0;
      trap_q  <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      nest_q  <= nest_d;
      flush_q <= (state_d == ST_FLUSH);
      taken_q <= (state_d == ST_ENTER);
      trap_q  <= trap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    nest_d  = nest_q;
    trap_d  = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (take_c) begin
          state_d = ST_FLUSH;
          cause_d = win_cause_c;
        end
      end

      ST_FLUSH: begin
        if (bus.pipe_drained) begin
          state_d      = ST_ENTER;
          trap_d.pc    = target_c;
          trap_d.cause = {1'b1, 27'b0, cause_q};
          trap_d.epc   = bus.retire_pc & 32'hFFFF_FFFC;
        end
      end

      ST_ENTER: begin
        nest_d  = nest_q + NEST_W'(1);
        state_d = ST_HANDLER;
      end

      ST_HANDLER: begin
        // MRET has precedence; take_c is already gated by mret_exec.
        if (bus.mret_exec) begin
          if (nest_q != '0) begin
            nest_d = nest_q - NEST_W'(1);
          end
          if (nest_q <= NEST_W'(1)) begin
            state_d = ST_IDLE;
          end
        end else if (take_c) begin
          state_d = ST_FLUSH;
          cause_d = win_cause_c;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.pipe_flush_req = flush_q;
  assign bus.trap_taken     = taken_q;
  assign bus.trap_pc        = trap_q.pc;
  assign bus.trap_cause     = trap_q.cause;
  assign bus.trap_epc       = trap_q.epc;
  assign bus.mip            = mip_c;
  assign bus.nest_depth     = nest_q;

endmodule

// File: tb/tb_irq_trap_ctrl.sv
// Directed self-checking bench for irq_trap_ctrl; outputs sampled on the falling edge.
module tb_irq_trap_ctrl;
  import irq_pkg::*;

  localparam int unsigned NEST_W = 2;

  logic clk       = 1'b0;
  logic reset_n   = 1'b0;
  logic irq_ext   = 1'b0;
  logic irq_sw    = 1'b0;
  logic irq_timer = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  irq_trap_ctrl_if #(.NEST_W(NEST_W)) bus ();

  irq_trap_ctrl #(.MAX_NEST(2), .NEST_W(NEST_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .irq_ext   (irq_ext),
    .irq_sw    (irq_sw),
    .irq_timer (irq_timer),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic mret_pulse();
    bus.mret_exec = 1'b1;
    step();
    bus.mret_exec = 1'b0;
  endtask

  task automatic wait_trap(input string tag);
    int n = 0;
    while (bus.trap_taken !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    if (bus.trap_taken !== 1'b1) check(tag, 32'd0, 32'd1);
  endtask

  task automatic wait_flush(input string tag);
    int n = 0;
    while (bus.pipe_flush_req !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    if (bus.pipe_flush_req !== 1'b1) check(tag, 32'd0, 32'd1);
  endtask

  logic [31:0] exp_vec_pc_b;
  logic [31:0] exp_vec_pc_3;
  int          cnt;

  initial begin
`ifdef IRQ_VECTORED_EN
    exp_vec_pc_b = 32'h0000_022C;
    exp_vec_pc_3 = 32'h0000_020C;
`else
    exp_vec_pc_b = 32'h0000_0200;
    exp_vec_pc_3 = 32'h0000_0200;
`endif
    bus.mstatus_mie  = 1'b0;
    bus.mie          = '0;
    bus.mtvec        = '0;
    bus.pipe_drained = 1'b0;
    bus.retire_pc    = '0;
    bus.mret_exec    = 1'b0;

    // Reset state
    step(); step();
    check("rst_flush", 32'(bus.pipe_flush_req), 32'd0);
    check("rst_taken", 32'(bus.trap_taken), 32'd0);
    check("rst_mip",   bus.mip, 32'd0);
    check("rst_nest",  32'(bus.nest_depth), 32'd0);
    check("rst_pc",    bus.trap_pc, 32'd0);
    reset_n = 1'b1;
    step();

    // Timer trap, direct mode
    bus.mtvec = 32'h100; bus.mie = 32'h80; bus.mstatus_mie = 1'b1;
    bus.pipe_drained = 1'b1; bus.retire_pc = 32'h2A6; irq_timer = 1'b1;
    step();
    check("t1_mip",    bus.mip, 32'h80);
    check("t1_noflush", 32'(bus.pipe_flush_req), 32'd0);
    step();
    check("t1_flush",  32'(bus.pipe_flush_req), 32'd1);
    check("t1_notaken", 32'(bus.trap_taken), 32'd0);
    step();
    check("t1_taken",  32'(bus.trap_taken), 32'd1);
    check("t1_pc",     bus.trap_pc, 32'h100);
    check("t1_cause",  bus.trap_cause, 32'h8000_0007);
    check("t1_epc",    bus.trap_epc, 32'h2A4);
    check("t1_flush_drop", 32'(bus.pipe_flush_req), 32'd0);
    irq_timer = 1'b0;
    step();
    check("t1_pulse",  32'(bus.trap_taken), 32'd0);
    check("t1_pc_zero", bus.trap_pc, 32'd0);
    check("t1_nest",   32'(bus.nest_depth), 32'd1);
    mret_pulse();
    check("t1_mret_nest", 32'(bus.nest_depth), 32'd0);

    // External sync latency and priority, vectored base 0x200
    bus.mtvec = 32'h201; bus.mie = 32'h888; bus.mstatus_mie = 1'b0; bus.retire_pc = 32'h1003;
    irq_ext = 1'b1;
    step();
    check("ext_1edge", bus.mip, 32'd0);
    step();
    check("ext_2edge", bus.mip, 32'h800);
    irq_sw = 1'b1; irq_timer = 1'b1;
    step();
    check("all_mip", bus.mip, 32'h888);
    bus.mstatus_mie = 1'b1;
    wait_trap("t2_timeout");
    check("t2_cause", bus.trap_cause, 32'h8000_000B);
    check("t2_pc",    bus.trap_pc, exp_vec_pc_b);
    check("t2_epc",   bus.trap_epc, 32'h1000);
    irq_ext = 1'b0; irq_sw = 1'b0; irq_timer = 1'b0; bus.mstatus_mie = 1'b0;
    step();
    mret_pulse();
    step(); step();
    irq_sw = 1'b1; irq_timer = 1'b1;
    step();
    bus.mstatus_mie = 1'b1;
    wait_trap("t2b_timeout");
    check("t2b_cause", bus.trap_cause, 32'h8000_0003);
    check("t2b_pc",    bus.trap_pc, exp_vec_pc_3);
    irq_sw = 1'b0; irq_timer = 1'b0; bus.mstatus_mie = 1'b0;
    step();
    mret_pulse();

    // Drain handshake with cause freeze
    bus.mtvec = 32'h100; bus.mie = 32'h80; bus.pipe_drained = 1'b0;
    bus.retire_pc = 32'h44; irq_timer = 1'b1; bus.mstatus_mie = 1'b1;
    wait_flush("t3_flush_timeout");
    cnt = 0;
    for (int i = 1; i <= 6; i++) begin
      if (bus.pipe_flush_req === 1'b1 && bus.trap_taken === 1'b0) cnt++;
      if (i == 2) irq_timer = 1'b0;
      if (i == 6) bus.pipe_drained = 1'b1;
      step();
    end
    check("t3_flush_cycles", 32'(cnt), 32'd6);
    check("t3_taken",  32'(bus.trap_taken), 32'd1);
    check("t3_flush_drop", 32'(bus.pipe_flush_req), 32'd0);
    check("t3_cause_frozen", bus.trap_cause, 32'h8000_0007);
    check("t3_epc",    bus.trap_epc, 32'h44);
    bus.mstatus_mie = 1'b0;
    step();
    mret_pulse();

    // Nesting limit
    irq_timer = 1'b1; bus.mstatus_mie = 1'b1;
    wait_trap("t4a_timeout");
    step();
    check("t4_nest1", 32'(bus.nest_depth), 32'd1);
    wait_trap("t4b_timeout");
    step();
    check("t4_nest2", 32'(bus.nest_depth), 32'd2);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.pipe_flush_req !== 1'b0 || bus.trap_taken !== 1'b0) cnt++;
      step();
    end
    check("t4_no_third", 32'(cnt), 32'd0);
    check("t4_nest_hold", 32'(bus.nest_depth), 32'd2);
    bus.mstatus_mie = 1'b0; irq_timer = 1'b0;
    mret_pulse();
    check("t4_mret1", 32'(bus.nest_depth), 32'd1);
    check("t4_mret1_noflush", 32'(bus.pipe_flush_req), 32'd0);
    mret_pulse();
    check("t4_mret2", 32'(bus.nest_depth), 32'd0);
    check("t4_idle", 32'(dut.state_q), 32'(ST_IDLE));

    // MRET coincident with take
    irq_timer = 1'b1; bus.mstatus_mie = 1'b1;
    wait_trap("t5_timeout");
    irq_timer = 1'b0; bus.mstatus_mie = 1'b0;
    step();
    irq_timer = 1'b1;
    step();
    check("t5_mip", bus.mip, 32'h80);
    bus.mstatus_mie = 1'b1;
    mret_pulse();
    check("t5_nest", 32'(bus.nest_depth), 32'd0);
    check("t5_no_flush", 32'(bus.pipe_flush_req), 32'd0);
    step();
    check("t5_flush_after", 32'(bus.pipe_flush_req), 32'd1);
    wait_trap("t5b_timeout");
    irq_timer = 1'b0; bus.mstatus_mie = 1'b0;
    step();
    mret_pulse();

    // Spurious MRET in IDLE
    check("t5s_idle", 32'(dut.state_q), 32'(ST_IDLE));
    mret_pulse();
    check("t5s_nest", 32'(bus.nest_depth), 32'd0);
    check("t5s_flush", 32'(bus.pipe_flush_req), 32'd0);

    // Asynchronous reset during a nested FLUSH
    irq_timer = 1'b1; bus.mstatus_mie = 1'b1; bus.pipe_drained = 1'b1;
    wait_trap("t6_timeout");
    bus.pipe_drained = 1'b0;
    step(); step();
    check("t6_pre_flush", 32'(bus.pipe_flush_req), 32'd1);
    check("t6_pre_nest",  32'(bus.nest_depth), 32'd1);
    check("t6_pre_mip",   bus.mip, 32'h80);
    #2 reset_n = 1'b0;
    #1;
    check("t6_rst_flush", 32'(bus.pipe_flush_req), 32'd0);
    check("t6_rst_mip",   bus.mip, 32'd0);
    check("t6_rst_nest",  32'(bus.nest_depth), 32'd0);
    irq_timer = 1'b0; bus.mstatus_mie = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    check("t6_idle", 32'(dut.state_q), 32'(ST_IDLE));
    check("t6_flush_after", 32'(bus.pipe_flush_req), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
